video_stream_gen: RTL and testbench
===================================

# video_stream_gen

Synthesizable video stream transmitter that produces the multi-pixel-per-clock stream consumed by `video_stream_to_window`.
- Outputs: pixel words, per-pixel valid mask, and line/frame start/end strobes, with horizontal and vertical blanking.
- Content: selectable test patterns for on-board bring-up.
- Placement: sits at the head of the processing chain, in place of the sensor/receiver path.

## Interface
- `PX_WIDTH`, 12, bits per pixel
- `PX_PER_CLK`, 4, pixels per word
- `RES_X`, 1936, active pixels per line
- `TOTAL_X`, 2200, total pixel slots per line; must be a multiple of `PX_PER_CLK`; `TOTAL_X/PX_PER_CLK` must exceed the number of active words
- `RES_Y`, 1096, active lines
- `TOTAL_Y`, 1125, total lines; must exceed `RES_Y`
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; synchronous, active-high
- `en_i`  in  1  run request; sampled only at frame boundary
- `pattern_sel_i`  in  2  test pattern select; latched at frame start
- `px_data_o`  out  `PX_PER_CLK*PX_WIDTH`  pixel word, packed `[PX_PER_CLK-1:0][PX_WIDTH-1:0]`; pixel 0 is leftmost
- `px_data_val_o`  out  `PX_PER_CLK`  per-pixel valid
- `line_start_o`  out  1  first active word of a line
- `line_end_o`  out  1  last active word of a line
- `frame_start_o`  out  1  first active word of a frame
- `frame_end_o`  out  1  last active word of a frame
- `frame_cnt_o`  out  16  completed frames, wraps at 2^16

## Operation
- Definitions:
  - W = ceil(RES_X/PX_PER_CLK), active words per line
  - TW = TOTAL_X/PX_PER_CLK, total words per line
  - L = RES_X mod PX_PER_CLK, pixels in a partial last word
- Counters: word counter x in 0..TW-1, line counter y in 0..TOTAL_Y-1.
- FSM states:
  - IDLE: outputs zero, counters held at 0.
  - IDLE -> RUN: when `en_i`=1.
  - RUN: x increments every cycle; on x=TW-1, x wraps to 0 and y increments.
  - RUN -> IDLE: when x=TW-1, y=TOTAL_Y-1 and `en_i`=0. Otherwise y wraps to 0 and RUN continues.
  - Deasserting `en_i` mid-frame completes the frame including vertical blanking.
- Active word: y<RES_Y and x<W.
  - `px_data_val_o`='1, except the last word (x=W-1) when L>0, which uses mask (1<<L)-1. Example: L=2 -> 4'b0011.
  - Invalid pixel lanes carry 0.
- Blanking word: all outputs 0.
- Strobes, all asserted on active words only:
  - `line_start_o`: x=0
  - `line_end_o`: x=W-1
  - `frame_start_o`: x=0, y=0
  - `frame_end_o`: x=W-1, y=RES_Y-1
- Patterns: px = x*PX_PER_CLK+i for lane i; all values mod 2^PX_WIDTH.
  - 0 RAMP: px+y
  - 1 CHECKER: all-ones if bit 3 of px XOR bit 3 of y, else 0
  - 2 FRAME: `frame_cnt_o[PX_WIDTH-1:0]`, every pixel of the frame
  - 3 INDEX: y*RES_X+px
- `frame_cnt_o` increments in the cycle after the `frame_end_o` word.

## Timing
- All outputs are registered.
- Reset: every output is 0 and the FSM is IDLE from the cycle after `rst_i` is sampled high. Reset mid-frame aborts immediately with no end strobes.
- Latency: `en_i` sampled high in IDLE at edge N -> frame start word (`frame_start_o`, `line_start_o`) is present after edge N+1.
- Frame period in RUN: TW*TOTAL_Y cycles, no gaps between back-to-back frames.
- Start/end coincidence: when W=1, `line_start_o` and `line_end_o` are asserted in the same cycle.
- `pattern_sel_i` changes take effect only from the next `frame_start_o`.
- No backpressure: the downstream block must accept one word per cycle.

## Structure
- `video_gen_pkg`:
  - `pattern_t` enum (RAMP, CHECKER, FRAME, INDEX)
  - function computing W, L and the last-word mask from the parameters
- Sub-module `video_px_pattern`: computes one pixel value from (px, y, frame count, pattern). Instantiated PX_PER_CLK times inside a generate loop.
- Top level holds the FSM, counters, strobe logic and output registers.
- Elaboration-time assertions check the parameter constraints.

## Test plan
Small-parameter bench: RES_X=10, PX_PER_CLK=4, TOTAL_X=16, RES_Y=3, TOTAL_Y=5. This gives W=3, TW=4, L=2, and a 20-cycle frame.
- Reset then idle with `en_i`=0 -> all outputs 0 for 50 cycles.
- `en_i`=1, pattern 0 -> per line, masks 4'hF, 4'hF, 4'h3 then one zero word.
  - Line 1 word 0 = {4,3,2,1} (lane 3..0).
  - `frame_end_o` on the 11th cycle of the frame.
- `en_i` dropped at cycle 5 of a frame -> frame completes; IDLE after 20 cycles; `frame_cnt_o`=1.
- Pattern 2 held over 3 back-to-back frames -> pixel values 0, 1, 2; `frame_start_o` spacing exactly 20 cycles.
- `pattern_sel_i` switched 3->1 mid-frame -> no change until the next `frame_start_o`.
- `rst_i` pulsed mid-line -> outputs 0 the next cycle; no `frame_end_o` emitted; `frame_cnt_o`=0.

Source files
------------

// File: rtl/video_gen_pkg.sv
// Shared types and parameter-derived helpers for the video stream generator.
package video_gen_pkg;

  typedef enum logic [1:0] {
    RAMP    = 2'd0,
    CHECKER = 2'd1,
    FRAME   = 2'd2,
    INDEX   = 2'd3
  } pattern_t;

  // Number of words needed to carry one active line (W).
  function automatic int unsigned active_words(input int unsigned res_x,
                                               input int unsigned ppc);
    return (res_x + ppc - 1) / ppc;
  endfunction

  // Pixels in a partial last word (L); 0 when the line fills whole words.
  function automatic int unsigned last_len(input int unsigned res_x,
                                           input int unsigned ppc);
    return res_x % ppc;
  endfunction

  // Valid mask of the last active word; all lanes valid when L is 0.
  function automatic logic [31:0] last_mask(input int unsigned res_x,
                                            input int unsigned ppc);
    int unsigned l;
    l = last_len(res_x, ppc);
    if (l == 0) return (32'd1 << ppc) - 32'd1;
    return (32'd1 << l) - 32'd1;
  endfunction

endpackage

// File: rtl/video_px_pattern.sv
// One pixel of test-pattern content from its column, line, frame count and pattern.
module video_px_pattern
  import video_gen_pkg::*;
#(
  parameter int unsigned PX_WIDTH = 12,
  parameter int unsigned RES_X    = 1936
) (
  input  logic [31:0]         px_i,
  input  logic [31:0]         y_i,
  input  logic [PX_WIDTH-1:0] frame_i,
  input  pattern_t            pattern_i,
  output logic [PX_WIDTH-1:0] px_o
);

  // Pattern select; all arithmetic is truncated to the pixel width.
  always_comb begin
    px_o = '0;
    case (pattern_i)
      RAMP:    px_o = PX_WIDTH'(px_i + y_i);
      CHECKER: px_o = (px_i[3] ^ y_i[3]) ? '1 : '0;
      FRAME:   px_o = frame_i;
      INDEX:   px_o = PX_WIDTH'(y_i * RES_X + px_i);
      default: px_o = '0;
    endcase
  end

endmodule

// File: rtl/video_stream_gen.sv
// Multi-pixel-per-clock test pattern stream generator with blanking and strobes.
module video_stream_gen
  import video_gen_pkg::*;
#(
  parameter int unsigned PX_WIDTH   = 12,
  parameter int unsigned PX_PER_CLK = 4,
  parameter int unsigned RES_X      = 1936,
  parameter int unsigned TOTAL_X    = 2200,
  parameter int unsigned RES_Y      = 1096,
  parameter int unsigned TOTAL_Y    = 1125
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic [1:0]                     pattern_sel_i,
  output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
  output logic [PX_PER_CLK-1:0]          px_data_val_o,
  output logic                           line_start_o,
  output logic                           line_end_o,
  output logic                           frame_start_o,
  output logic                           frame_end_o,
  output logic [15:0]                    frame_cnt_o
);

  localparam int unsigned W  = active_words(RES_X, PX_PER_CLK);
  localparam int unsigned TW = TOTAL_X / PX_PER_CLK;
  localparam int unsigned XW = (TW > 1) ? $clog2(TW) : 1;
  localparam int unsigned YW = (TOTAL_Y > 1) ? $clog2(TOTAL_Y) : 1;

  localparam logic [31:0]           MASK_FULL = last_mask(RES_X, PX_PER_CLK);
  localparam logic [PX_PER_CLK-1:0] LAST_MASK = MASK_FULL[PX_PER_CLK-1:0];

  localparam logic [XW-1:0] X_LAST     = XW'(TW - 1);
  localparam logic [XW-1:0] X_ACT      = XW'(W);
  localparam logic [XW-1:0] X_ACT_LAST = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(TOTAL_Y - 1);
  localparam logic [YW-1:0] Y_ACT      = YW'(RES_Y);
  localparam logic [YW-1:0] Y_ACT_LAST = YW'(RES_Y - 1);

  if (PX_PER_CLK == 0 || RES_X == 0 || RES_Y == 0) begin : g_chk_nonzero
    $error("video_stream_gen: PX_PER_CLK, RES_X and RES_Y must be non-zero");
  end
  if (TOTAL_X % PX_PER_CLK != 0) begin : g_chk_total_x_mult
    $error("video_stream_gen: TOTAL_X must be a multiple of PX_PER_CLK");
  end
  if (TW <= W) begin : g_chk_hblank
    $error("video_stream_gen: TOTAL_X/PX_PER_CLK must exceed the active word count");
  end
  if (TOTAL_Y <= RES_Y) begin : g_chk_vblank
    $error("video_stream_gen: TOTAL_Y must exceed RES_Y");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                        state_q, state_d;
  logic [XW-1:0]                 x_q, x_d;
  logic [YW-1:0]                 y_q, y_d;
  pattern_t                      pat_q, pat_d;
  logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_q, px_data_d;
  logic [PX_PER_CLK-1:0]         px_val_q, px_val_d;
  logic                          line_start_q, line_start_d;
  logic                          line_end_q, line_end_d;
  logic                          frame_start_q, frame_start_d;
  logic                          frame_end_q, frame_end_d;
  logic [15:0]                   frame_cnt_q, frame_cnt_d;

  logic                          run;
  logic                          active;
  logic                          at_origin;
  pattern_t                      pat_cur;
  logic [PX_WIDTH-1:0]           lane_px [PX_PER_CLK];

  // Pattern is taken live on the frame's first word and held for the rest of it.
  always_comb begin
    run       = (state_q == S_RUN);
    at_origin = run && (x_q == '0) && (y_q == '0);
    pat_cur   = at_origin ? pattern_t'(pattern_sel_i) : pat_q;
    pat_d     = pat_cur;
  end

  for (genvar i = 0; i < PX_PER_CLK; i++) begin : g_lane
    video_px_pattern #(
      .PX_WIDTH (PX_WIDTH),
      .RES_X    (RES_X)
    ) u_px_pattern (
      .px_i      (32'(x_q) * PX_PER_CLK + i),
      .y_i       (32'(y_q)),
      .frame_i   (PX_WIDTH'(frame_cnt_q)),
      .pattern_i (pat_cur),
      .px_o      (lane_px[i])
    );
  end

  // Run/idle control and raster counters; a stop request only ends at frame boundary.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (en_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d = '0;
            if (!en_i) state_d = S_IDLE;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next output word: lane masks, blanked pixel data and position strobes.
  always_comb begin
    active        = run && (y_q < Y_ACT) && (x_q < X_ACT);
    px_val_d      = '0;
    px_data_d     = '0;
    line_start_d  = 1'b0;
    line_end_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    if (active) begin
      px_val_d      = (x_q == X_ACT_LAST) ? LAST_MASK : '1;
      line_start_d  = (x_q == '0);
      line_end_d    = (x_q == X_ACT_LAST);
      frame_start_d = (x_q == '0) && (y_q == '0);
      frame_end_d   = (x_q == X_ACT_LAST) && (y_q == Y_ACT_LAST);
    end
    for (int unsigned i = 0; i < PX_PER_CLK; i++) begin
      px_data_d[i*PX_WIDTH +: PX_WIDTH] = px_val_d[i] ? lane_px[i] : '0;
    end
    frame_cnt_d = frame_cnt_q + 16'(frame_end_q);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      pat_q         <= RAMP;
      px_data_q     <= '0;
      px_val_q      <= '0;
      line_start_q  <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pat_q         <= pat_d;
      px_data_q     <= px_data_d;
      px_val_q      <= px_val_d;
      line_start_q  <= line_start_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign px_data_o     = px_data_q;
  assign px_data_val_o = px_val_q;
  assign line_start_o  = line_start_q;
  assign line_end_o    = line_end_q;
  assign frame_start_o = frame_start_q;
  assign frame_end_o   = frame_end_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Scoreboard bench for video_stream_gen using a raster-position reference model.
module tb_video_stream_gen;

  localparam int PW      = 12;
  localparam int PPC     = 4;
  localparam int RES_X   = 10;
  localparam int TOTAL_X = 16;
  localparam int RES_Y   = 3;
  localparam int TOTAL_Y = 5;
  localparam int TW      = TOTAL_X / PPC;
  localparam int FLEN    = TW * TOTAL_Y;
  localparam int DW      = PPC * PW;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [PPC-1:0] val;
    logic           ls;
    logic           le;
    logic           fs;
    logic           fe;
    logic [15:0]    cnt;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic [1:0]    pattern_sel_i = 2'd0;
  logic [DW-1:0] px_data_o;
  logic [PPC-1:0] px_data_val_o;
  logic          line_start_o, line_end_o, frame_start_o, frame_end_o;
  logic [15:0]   frame_cnt_o;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  video_stream_gen #(
    .PX_WIDTH   (PW),
    .PX_PER_CLK (PPC),
    .RES_X      (RES_X),
    .TOTAL_X    (TOTAL_X),
    .RES_Y      (RES_Y),
    .TOTAL_Y    (TOTAL_Y)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .pattern_sel_i (pattern_sel_i),
    .px_data_o     (px_data_o),
    .px_data_val_o (px_data_val_o),
    .line_start_o  (line_start_o),
    .line_end_o    (line_end_o),
    .frame_start_o (frame_start_o),
    .frame_end_o   (frame_end_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  // Expected word for raster position pos of a frame, from pixel coordinates.
  function automatic obs_t word_at(int pos, int pat, int cnt);
    obs_t o;
    int x, y, p, v;
    o = '0;
    x = pos % TW;
    y = pos / TW;
    if (y < RES_Y && x * PPC < RES_X) begin
      for (int i = 0; i < PPC; i++) begin
        p = x * PPC + i;
        if (p < RES_X) begin
          case (pat)
            0:       v = p + y;
            1:       v = (((p >> 3) ^ (y >> 3)) & 1) != 0 ? (1 << PW) - 1 : 0;
            2:       v = cnt;
            default: v = y * RES_X + p;
          endcase
          o.val[i] = 1'b1;
          o.data[i*PW +: PW] = v[PW-1:0];
        end
      end
      o.ls = (x == 0);
      o.le = ((x + 1) * PPC >= RES_X);
      o.fs = (x == 0) && (y == 0);
      o.fe = o.le && (y == RES_Y - 1);
    end
    return o;
  endfunction

  // Reference model: at each edge push what the DUT should show after it.
  initial begin : model
    bit   m_run;
    int   m_pos, m_cnt, m_pat;
    obs_t e;
    m_run = 0; m_pos = 0; m_cnt = 0; m_pat = 0;
    forever begin
      @(posedge clk);
      if (rst_i) begin
        m_run = 0; m_pos = 0; m_cnt = 0;
        e = '0;
      end else begin
        if (m_run) begin
          if (m_pos == 0) m_pat = int'(pattern_sel_i);
          e = word_at(m_pos, m_pat, m_cnt);
        end else begin
          e = '0;
        end
        e.cnt = m_cnt[15:0];
        if (e.fe) m_cnt = (m_cnt + 1) % 65536;
        if (m_run) begin
          m_pos++;
          if (m_pos == FLEN) begin
            m_pos = 0;
            if (!en_i) m_run = 0;
          end
        end else if (en_i) begin
          m_run = 1;
          m_pos = 0;
        end
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: every cycle the DUT presents a word; compare it with the model.
  initial begin : monitor
    obs_t g, e;
    forever begin
      @(negedge clk);
      g = {px_data_o, px_data_val_o, line_start_o, line_end_o,
           frame_start_o, frame_end_o, frame_cnt_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got data=%h with no expected entry", $time, g.data);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL word t=%0t got data=%h val=%h ls=%b le=%b fs=%b fe=%b cnt=%0d expected data=%h val=%h ls=%b le=%b fs=%b fe=%b cnt=%0d",
                   $time, g.data, g.val, g.ls, g.le, g.fs, g.fe, g.cnt,
                   e.data, e.val, e.ls, e.le, e.fs, e.fe, e.cnt);
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Align to the next frame start word, bounded.
  task automatic wait_fs();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_start_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!frame_start_o) begin
      errors++;
      $display("FAIL frame_start_timeout got none after %0d cycles, required within 200", n);
    end
  endtask

  initial begin : driver
    cyc(3);
    rst_i = 1'b0;
    cyc(50);                        // idle with en low

    en_i = 1'b1; pattern_sel_i = 2'd0;
    cyc(45);

    wait_fs();                      // drop run request early in a frame
    cyc(4);
    en_i = 1'b0;
    cyc(40);

    en_i = 1'b1; pattern_sel_i = 2'd2;
    cyc(65);

    pattern_sel_i = 2'd3;
    wait_fs();
    cyc(6);
    pattern_sel_i = 2'd1;           // mid-frame change, visible next frame only
    cyc(40);

    for (int i = 0; i < 400; i++) begin
      en_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) pattern_sel_i = 2'($urandom_range(0, 3));
      rst_i = ($urandom_range(0, 149) == 0);
      cyc(1);
    end
    rst_i = 1'b0; en_i = 1'b1;

    wait_fs();                      // reset pulse mid-line
    cyc(5);
    rst_i = 1'b1;
    cyc(1);
    rst_i = 1'b0; en_i = 1'b0;
    cyc(25);

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
